// File: rtl/sram_d_port_arbiter.sv
// Two-master OBI arbiter for the SRAM data port: fixed priority to master 0 with a
// starvation override for master 1, plus an ID FIFO that routes responses back.
module sram_d_port_arbiter #(
  parameter int MAX_WAIT    = 4,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        resp_err_o
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int SLOTS = 1 << PTR_W;

  logic [3:0]       wait_cnt;
  logic             starve;
  logic             win1;
  logic             accept;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic             head;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             ids [SLOTS];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration and request mux
  assign starve = (wait_cnt == 4'(MAX_WAIT));
  assign win1   = m1_req_i & (~m0_req_i | starve);

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_W'(OUTSTANDING));
  assign pop    = s_rvalid_i & ~empty & ~rst_i;
  // A full FIFO still accepts when its head retires this cycle, keeping 1 txn/cycle.
  assign accept = ~full | pop;

  assign s_req_o   = (m0_req_i | m1_req_i) & accept & ~rst_i;
  assign push      = s_req_o & s_gnt_i;
  assign m0_gnt_o  = push & ~win1;
  assign m1_gnt_o  = push & win1;

  assign s_addr_o  = win1 ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = win1 ? m1_we_i    : m0_we_i;
  assign s_be_o    = win1 ? m1_be_i    : m0_be_i;
  assign s_wdata_o = win1 ? m1_wdata_i : m0_wdata_i;

  // Response routing from the FIFO head
  assign head        = ids[rd_ptr];
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!m1_req_i || m1_gnt_o) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      ids[wr_ptr] <= win1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_err_o <= 1'b0;
    end else if (s_rvalid_i && empty) begin
      resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_d_port_arbiter.sv
// Directed bench for sram_d_port_arbiter: a 2-deep instance driven through a small
// SRAM model, and a 1-deep instance driven by hand for the back-pressure case.
module tb_sram_d_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_gnt, s_we, s_rvalid, resp_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  logic        resp_en, force_rv, rv_q;
  logic [31:0] rd_q;
  logic [31:0] mem [16];

  logic        b_m0_req, b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic        b_s_req, b_s_we, b_s_rvalid, b_resp_err;
  logic [3:0]  b_s_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign s_rvalid = (rv_q & resp_en) | force_rv;
  assign s_rdata  = rd_q;

  sram_d_port_arbiter #(.MAX_WAIT(4), .OUTSTANDING(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_we_i(m0_we), .m1_we_i(m1_we),
    .m0_be_i(m0_be), .m1_be_i(m1_be), .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .resp_err_o(resp_err)
  );

  sram_d_port_arbiter #(.MAX_WAIT(4), .OUTSTANDING(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(b_m0_req), .m1_req_i(1'b0), .m0_gnt_o(b_m0_gnt), .m1_gnt_o(b_m1_gnt),
    .m0_addr_i(32'h8000_0000), .m1_addr_i(32'h0), .m0_we_i(1'b0), .m1_we_i(1'b0),
    .m0_be_i(4'hF), .m1_be_i(4'h0), .m0_wdata_i(32'h0), .m1_wdata_i(32'h0),
    .m0_rvalid_o(b_m0_rvalid), .m1_rvalid_o(b_m1_rvalid),
    .m0_rdata_o(b_m0_rdata), .m1_rdata_o(b_m1_rdata),
    .s_req_o(b_s_req), .s_gnt_i(1'b1), .s_addr_o(b_s_addr), .s_we_o(b_s_we),
    .s_be_o(b_s_be), .s_wdata_o(b_s_wdata), .s_rvalid_i(b_s_rvalid),
    .s_rdata_i(32'h5555_AAAA), .resp_err_o(b_resp_err)
  );

  // SRAM model: one-cycle response for every accepted request, writes use all lanes
  always @(posedge clk) begin
    if (s_req && s_gnt) begin
      rv_q <= 1'b1;
      rd_q <= mem[s_addr[5:2]];
      if (s_we) mem[s_addr[5:2]] <= s_wdata;
    end else begin
      rv_q <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hD000_0000 | i;
    rv_q = 1'b0; rd_q = '0;
    rst = 1'b1; resp_en = 1'b1; force_rv = 1'b0; s_gnt = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h8000_0000; m1_addr = 32'h8000_0004;
    m0_we = 1'b0; m1_we = 1'b0; m0_be = 4'hF; m1_be = 4'hF;
    m0_wdata = '0; m1_wdata = '0;
    b_m0_req = 1'b1; b_s_rvalid = 1'b0;

    // Reset: requests present, everything gated
    @(negedge clk);
    check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    check("rst_s_req", {31'b0, s_req}, 32'd0);
    check("rst_b_gnt", {31'b0, b_m0_gnt}, 32'd0);
    next_cycle();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; b_m0_req = 1'b0;
    @(negedge clk);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    next_cycle();

    // Master 0 burst of four reads, one-cycle SRAM latency
    for (int i = 0; i < 5; i++) begin
      m0_req  = (i < 4);
      m0_addr = 32'h8000_0000 + 32'(i * 4);
      @(negedge clk);
      if (i < 4) check("burst_gnt", {31'b0, m0_gnt}, 32'd1);
      if (i > 0) begin
        check("burst_rv", {31'b0, m0_rvalid}, 32'd1);
        check("burst_rdata", m0_rdata, 32'hD000_0000 | 32'(i - 1));
      end else begin
        check("burst_rv0", {31'b0, m0_rvalid}, 32'd0);
      end
      check("burst_m1_rv", {31'b0, m1_rvalid}, 32'd0);
      next_cycle();
    end
    m0_req = 1'b0;
    @(negedge clk);
    check("burst_idle_rv", {31'b0, m0_rvalid}, 32'd0);
    next_cycle();

    // Both masters requesting: master 1 forced through every fifth cycle
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h8000_0000; m1_addr = 32'h8000_0004;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("starve_m0_gnt", {31'b0, m0_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
      check("starve_m1_gnt", {31'b0, m1_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    check("starve_last_m1_rv", {31'b0, m1_rvalid}, 32'd1);
    check("starve_last_m0_rv", {31'b0, m0_rvalid}, 32'd0);
    check("starve_last_rdata", m1_rdata, 32'hD000_0001);
    next_cycle();

    // Interleaved: m0 read, m1 write, m1 read-back
    m0_req = 1'b1; m0_addr = 32'h8000_0010;
    @(negedge clk);
    check("il_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0020;
    m1_wdata = 32'hA5A5_A5A5; m1_be = 4'hF;
    @(negedge clk);
    check("il_wr_gnt", {31'b0, m1_gnt}, 32'd1);
    check("il_s_wdata", s_wdata, 32'hA5A5_A5A5);
    check("il_m0_rv", {31'b0, m0_rvalid}, 32'd1);
    check("il_m0_rdata", m0_rdata, 32'hD000_0004);
    next_cycle();
    m1_we = 1'b0;
    @(negedge clk);
    check("il_rd_gnt", {31'b0, m1_gnt}, 32'd1);
    check("il_wr_rv", {31'b0, m1_rvalid}, 32'd1);
    check("il_wr_m0_rv", {31'b0, m0_rvalid}, 32'd0);
    next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    check("il_rd_rv", {31'b0, m1_rvalid}, 32'd1);
    check("il_rd_rdata", m1_rdata, 32'hA5A5_A5A5);
    check("il_rd_m0_rv", {31'b0, m0_rvalid}, 32'd0);
    next_cycle();

    // Single-entry FIFO with three-cycle response delay
    b_m0_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      b_s_rvalid = (c == 3);
      @(negedge clk);
      check("o1_gnt", {31'b0, b_m0_gnt}, (c == 0 || c == 3) ? 32'd1 : 32'd0);
      check("o1_rv", {31'b0, b_m0_rvalid}, (c == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    b_m0_req = 1'b0; b_s_rvalid = 1'b1;
    @(negedge clk);
    check("o1_drain_rv", {31'b0, b_m0_rvalid}, 32'd1);
    check("o1_drain_gnt", {31'b0, b_m0_gnt}, 32'd0);
    next_cycle();
    b_s_rvalid = 1'b0;

    // Spurious response with nothing outstanding
    force_rv = 1'b1;
    @(negedge clk);
    check("sp_m0_rv", {31'b0, m0_rvalid}, 32'd0);
    check("sp_m1_rv", {31'b0, m1_rvalid}, 32'd0);
    check("sp_err_pre", {31'b0, resp_err}, 32'd0);
    next_cycle();
    force_rv = 1'b0;
    @(negedge clk);
    check("sp_err", {31'b0, resp_err}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("sp_err_sticky", {31'b0, resp_err}, 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("sp_err_clr", {31'b0, resp_err}, 32'd0);
    next_cycle();

    // Reset with two transactions outstanding
    resp_en = 1'b0; m0_req = 1'b1; m0_addr = 32'h8000_0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mb_gnt", {31'b0, m0_gnt}, (c < 2) ? 32'd1 : 32'd0);
      next_cycle();
    end
    rst = 1'b1; force_rv = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    check("mb_rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check("mb_rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    check("mb_rst_m0_rv", {31'b0, m0_rvalid}, 32'd0);
    check("mb_rst_m1_rv", {31'b0, m1_rvalid}, 32'd0);
    check("mb_rst_s_req", {31'b0, s_req}, 32'd0);
    next_cycle();
    rst = 1'b0; force_rv = 1'b0; m1_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mb_post_gnt", {31'b0, m0_gnt}, (c < 2) ? 32'd1 : 32'd0);
      next_cycle();
    end
    m0_req = 1'b0;
    @(negedge clk);
    check("mb_err", {31'b0, resp_err}, 32'd0);
    check("o1_err", {31'b0, b_resp_err}, 32'd0);
    check("o1_m1_quiet", {30'b0, b_m1_gnt, b_m1_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_d_port_arbiter.md
# sram_d_port_arbiter

Two-master arbiter that shares the single read/write (port 0, `sram_d`) OBI port of the 48 kB SRAM wrapper between the core data bus (master 0) and the DMA/debug bridge (master 1). It selects one request per cycle, with fixed priority to master 0 and a starvation counter that forces master 1 through after a bounded wait. It also tracks outstanding transactions in a small ID FIFO so each `rvalid`/`rdata` returns to the master that issued the request. It sits between the OBI crossbar outputs and the `sram_d_*` inputs of the SRAM wrapper.

## Interface
- `MAX_WAIT`, 4: cycles master 1 may be refused while requesting before it gets priority (1..15).
- `OUTSTANDING`, 2: depth of the response-ID FIFO, i.e. maximum granted-but-unanswered transactions (1..4).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `m0_req_i`, `m1_req_i`  in  1  OBI request, per master.
- `m0_gnt_o`, `m1_gnt_o`  out  1  OBI grant, per master.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_be_i`, `m1_be_i`  in  4  byte enables.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response valid.
- `m0_rdata_o`, `m1_rdata_o`  out  32  response data.
- `s_req_o`  out  1  request to the SRAM port.
- `s_gnt_i`  in  1  grant from the SRAM port.
- `s_addr_o`  out  32  address to the SRAM port.
- `s_we_o`  out  1  write enable to the SRAM port.
- `s_be_o`  out  4  byte enables to the SRAM port.
- `s_wdata_o`  out  32  write data to the SRAM port.
- `s_rvalid_i`  in  1  response valid from the SRAM port.
- `s_rdata_i`  in  32  response data from the SRAM port.
- `resp_err_o`  out  1  sticky flag: response arrived with no outstanding ID.

## Operation
- Arbitration runs combinationally each cycle.
  - Default: master 0 wins when both request.
  - Starvation override: master 1 wins when `wait_cnt == MAX_WAIT`.
- `accept` = FIFO not full, or FIFO full with `s_rvalid_i` popping this cycle.
- `s_req_o` = (`m0_req_i` | `m1_req_i`) & `accept` & ~`rst_i`.
- `s_addr_o`, `s_we_o`, `s_be_o` and `s_wdata_o` mux from the winner. They are driven from master 0 when idle.
- Grant to the winner: `mX_gnt_o` = winner & `s_req_o` & `s_gnt_i`. The loser's grant is 0.
- Handshake (`s_req_o & s_gnt_i`) pushes the winner ID (0/1) into the ID FIFO.
- `s_rvalid_i` pops the FIFO head.
  - Drives `mH_rvalid_o` = 1 and `mH_rdata_o` = `s_rdata_i` for head ID H, combinationally in the same cycle.
  - The other master sees `rvalid` = 0.
  - Both `rdata` outputs carry `s_rdata_i` whenever `rvalid` is 0.
- Push and pop in the same cycle: the count is unchanged, and entry order is preserved.
- `s_rvalid_i` with an empty FIFO, and no pop at reset: set `resp_err_o`. No `rvalid` is forwarded and the count stays 0. The flag clears only on reset.
- Starvation counter `wait_cnt`, 4 bits:
  - Increments when `m1_req_i` is high and `m1_gnt_o` is low.
  - Saturates at `MAX_WAIT`.
  - Clears to 0 when `m1_gnt_o` is high or `m1_req_i` is low.
- Writes occupy FIFO slots exactly like reads, because the SRAM returns `rvalid` for every request.

## Timing
- Reset values:
  - `wait_cnt` = 0, FIFO empty, `resp_err_o` = 0.
  - While `rst_i` is high, all `gnt`, `rvalid` and `s_req_o` outputs are 0. `rdata` and `s_*` data follow the mux (don't-care).
- Request path: zero added latency. Grant occurs in the same cycle as the request when the SRAM grants.
- Response path: zero added latency. Back-to-back throughput is 1 transaction/cycle with `OUTSTANDING` ≥ 1, because of the pop-when-full rule.
- Reset asserted with transactions outstanding: the FIFO is flushed. Responses arriving in the cycle after reset deassertion set `resp_err_o`. The SoC always resets the SRAM wrapper together with this block.
- A master that drops `req` before being granted is legal. It must hold `addr`/`we`/`be`/`wdata` stable while `req` is high and not granted.

## Test plan
- Master 0 only: reads to 0x8000_0000..0x8000_000C on consecutive cycles with the SRAM responding at 1 cycle. `m0_gnt_o` = 1 on every cycle. `m0_rvalid_o` follows one cycle later with the 4 data words in order. `m1_rvalid_o` stays 0.
- Both masters request continuously, `MAX_WAIT` = 4. Master 0 wins cycles 0–3. Master 1 wins cycle 4, then `wait_cnt` = 0. The pattern repeats with period 5.
- Interleaved traffic: m0 reads 0x8000_0010, then m1 writes 0xA5A5_A5A5 to 0x8000_0020 with `be` = 0xF, then m1 reads 0x8000_0020. Responses route to m0, m1, m1 respectively, and the m1 read returns 0xA5A5_A5A5.
- `OUTSTANDING` = 1, `s_gnt_i` = 1, `s_rvalid_i` delayed by 3 cycles. After one grant, no further `gnt` until the cycle `s_rvalid_i` arrives; a new grant occurs in that same cycle.
- Spurious `s_rvalid_i` pulse with an empty FIFO: `resp_err_o` rises the next cycle and stays 1. No master sees `rvalid`. `rst_i` for 1 cycle clears it.
- Reset mid-burst: `rst_i` pulsed with 2 transactions outstanding. All `gnt`/`rvalid` outputs are 0 during reset. The FIFO count is 0 after reset. The next m0 request is granted normally.
